// File: rtl/pc_pkg.sv
// Shared encodings and constants for the program-counter stage.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } src_t;

  localparam int          WORD_BYTES           = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational next-PC select: jr > jump > branch > sequential, plus alignment flag.
module pc_redirect_arbiter
  import pc_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                jr_en,
  input  logic [PC_WIDTH-1:0] jr_target,
  input  logic [PC_WIDTH-1:0] seq_target,
  output logic [PC_WIDTH-1:0] target,
  output src_t                src,
  output logic                misaligned
);

  always_comb begin
    target = seq_target;
    src    = SRC_SEQ;
    if (jr_en) begin
      target = jr_target;
      src    = SRC_JR;
    end else if (jump_en) begin
      target = jump_target;
      src    = SRC_J;
    end else if (branch_taken) begin
      target = branch_target;
      src    = SRC_BR;
    end
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall, single pending redirect and misaligned-target halt.
// Optional BRANCH_DELAY_SLOT_EN: redirects take effect after one delay-slot fetch.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                jr_en,
  input  logic [PC_WIDTH-1:0] jr_target,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                fetch_valid,
  output logic                fault
);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] sel_target;
  src_t                sel_src;
  logic                sel_misaligned;
  logic                sel_redirect;
  logic                arb_live;
  logic                bad;
  logic                pend_vld;
  logic [PC_WIDTH-1:0] pend_addr;
`ifdef BRANCH_DELAY_SLOT_EN
  logic                slot_done;
`endif

  assign pc_plus4 = pc_out + PC_WIDTH'(WORD_BYTES);

  pc_redirect_arbiter #(.PC_WIDTH(PC_WIDTH)) u_arb (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .seq_target    (pc_plus4),
    .target        (sel_target),
    .src           (sel_src),
    .misaligned    (sel_misaligned)
  );

  assign sel_redirect = (sel_src != SRC_SEQ);
  // Arbiter result only matters while nothing is pending; a held target was already checked.
  assign arb_live     = (state == RUN) && !pend_vld;
  assign bad          = arb_live && sel_misaligned;

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (bad) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      RUN:     fetch_valid = ~stall;
      HALT:    fault       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out    <= RESET_VECTOR;
      pend_vld  <= 1'b0;
      pend_addr <= RESET_VECTOR;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_done <= 1'b0;
`endif
    end else if (state == RUN && !bad) begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (!stall) begin
        if (pend_vld) begin
          if (slot_done) begin
            pc_out    <= pend_addr;
            pend_vld  <= 1'b0;
            slot_done <= 1'b0;
          end else begin
            pc_out    <= pc_plus4;
            slot_done <= 1'b1;
          end
        end else if (sel_redirect) begin
          pc_out    <= pc_plus4;
          pend_addr <= sel_target;
          pend_vld  <= 1'b1;
          slot_done <= 1'b1;
        end else begin
          pc_out <= pc_plus4;
        end
      end else if (!pend_vld && sel_redirect) begin
        pend_addr <= sel_target;
        pend_vld  <= 1'b1;
        slot_done <= 1'b0;
      end
`else
      if (!stall) begin
        if (pend_vld) begin
          pc_out   <= pend_addr;
          pend_vld <= 1'b0;
        end else begin
          pc_out <= sel_target;
        end
      end else if (!pend_vld && sel_redirect) begin
        pend_addr <= sel_target;
        pend_vld  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector/scoreboard bench for pc_sequencer (default build, or delay-slot build).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump_en, jr_en;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc_out, pc_plus4;
  logic        fetch_valid, fault;

  pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target),
    .jr_en(jr_en), .jr_target(jr_target),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, stl, br;
    logic [31:0] brt;
    bit          j;
    logic [31:0] jt;
    bit          jr;
    logic [31:0] jrt;
    bit          chk_fv, fv;
    logic [31:0] pc;
    bit          flt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    bit          flt;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   n      = 0;

  function automatic vec_t mk(input bit rst, stl, br, input logic [31:0] brt,
                              input bit j, input logic [31:0] jt,
                              input bit jr, input logic [31:0] jrt,
                              input bit chk_fv, fv, input logic [31:0] pc, input bit flt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
    v.jr = jr; v.jrt = jrt; v.chk_fv = chk_fv; v.fv = fv; v.pc = pc; v.flt = flt;
    return v;
  endfunction

  // Drive one cycle; fetch_valid is checked for the current cycle, pc/fault after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; stall = v.stl;
    branch_taken = v.br; branch_target = v.brt;
    jump_en = v.j; jump_target = v.jt;
    jr_en = v.jr; jr_target = v.jrt;
    #1;
    if (v.chk_fv) begin
      checks++;
      if (fetch_valid !== v.fv) begin
        fails++;
        $display("FAIL fetch_valid step %0d: got %b want %b", n, fetch_valid, v.fv);
      end
      checks++;
      if (pc_plus4 !== pc_out + 32'd4) begin
        fails++;
        $display("FAIL pc_plus4 step %0d: got %h want %h", n, pc_plus4, pc_out + 32'd4);
      end
    end
    e.pc = v.pc; e.flt = v.flt; e.idx = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (pc_out !== e.pc) begin
      fails++;
      $display("FAIL pc_out step %0d: got %h want %h", e.idx, pc_out, e.pc);
    end
    checks++;
    if (fault !== e.flt) begin
      fails++;
      $display("FAIL fault step %0d: got %b want %b", e.idx, fault, e.flt);
    end
    n++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0; jr_en = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0;

    //               rst stl br brt           j  jt            jr jrt          cfv fv pc            flt
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h4,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h8,        0));
`ifndef BRANCH_DELAY_SLOT_EN
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,      1, 1, 32'h100,      0));
    tbl.push_back(mk(0, 0, 1, 32'h500,      1, 32'h0040_0020,0, 32'h0,      1, 1, 32'h0040_0020,0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h900,      1, 32'h800,    1, 1, 32'h800,      0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,      1, 1, 32'h200,      0));
    tbl.push_back(mk(0, 1, 1, 32'h300,      0, 32'h0,        0, 32'h0,      1, 0, 32'h200,      0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h400,      0, 32'h0,      1, 0, 32'h200,      0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 0, 32'h200,      0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h600,    1, 1, 32'h300,      0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h304,      0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 32'h0,      1, 1, 32'hFFFF_FFFC,0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h4,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1002,   1, 1, 32'h4,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,      1, 0, 32'h4,        1));
    tbl.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,        0, 32'h0,      1, 0, 32'h4,        1));
`else
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,      1, 1, 32'hC,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h40,       0));
    tbl.push_back(mk(0, 0, 1, 32'h80,       0, 32'h0,        0, 32'h0,      1, 1, 32'h44,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h400,      0, 32'h0,      1, 1, 32'h80,       0));
    tbl.push_back(mk(0, 0, 1, 32'h200,      0, 32'h0,        0, 32'h0,      1, 1, 32'h84,       0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 0, 32'h84,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h200,      0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 1, 32'h204,      0));
`endif

    foreach (tbl[i]) apply(tbl[i]);

    // Reset out of HALT, stall ignored in BOOT, reset mid-pending, misaligned capture under stall.
    apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
    apply(mk(0, 1, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0));
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 1, 32'h4, 0));
    apply(mk(0, 1, 1, 32'h300, 0, 32'h0, 0, 32'h0, 1, 0, 32'h4, 0));
    apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0));
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 1, 32'h4, 0));
    apply(mk(0, 1, 1, 32'h302, 0, 32'h0, 0, 32'h0, 1, 0, 32'h4, 1));
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 0, 32'h4, 1));
    apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));

    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage that produces the fetch address for the MIPS CPU.
- Drives pc_plus4. Upper nibble pc_plus4[31:28] feeds the jump-target concatenator.
- Consumes the 32-bit concatenated jump target, the branch target and the jr register target, and selects the next PC.
- Handles stall, misaligned-target fault and a registered pending redirect.

Parameters:
- PC_WIDTH, 32, width of all address ports.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; 1 = no advance this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  PC_WIDTH  PC+4+(sext(imm)<<2).
- jump_en  in  1  j/jal redirect request.
- jump_target  in  PC_WIDTH  concatenated {pc_plus4[31:28], instr[25:0], 2'b00}.
- jr_en  in  1  jr/jalr redirect request.
- jr_target  in  PC_WIDTH  register-file value.
- pc_out  out  PC_WIDTH  current fetch address (registered).
- pc_plus4  out  PC_WIDTH  pc_out + 4 (combinational from pc_out).
- fetch_valid  out  1  pc_out is a valid fetch this cycle.
- fault  out  1  sticky misaligned-target fault.

Behaviour:
- Reset (synchronous, active-high, overrides everything, may arrive mid-operation or mid-pending):
  - pc_out=RESET_VECTOR; fetch_valid=0; fault=0; pending cleared; state=BOOT.
- FSM states BOOT, RUN, HALT:
  - BOOT: one cycle, fetch_valid=0, pc_out holds RESET_VECTOR, then RUN unconditionally (stall ignored in BOOT).
  - RUN: fetch_valid = ~stall.
  - HALT: pc_out frozen, fetch_valid=0, fault=1, all inputs ignored; exits only on reset.
- Redirect arbitration, evaluated each RUN cycle; priority jr_en > jump_en > branch_taken > sequential (pc_out+4).
  - Simultaneous requests: highest priority wins, the others are dropped, no error.
- RUN, stall=0, no pending:
  - pc_out <= selected target.
  - Latency: exactly 1 cycle from request to new pc_out.
- RUN, stall=1:
  - pc_out holds.
  - If a redirect is requested and no pending exists, capture the winning target into pend_addr and set pend_vld.
  - Further redirects while pend_vld=1 are ignored (first wins).
- RUN, stall=0, pend_vld=1:
  - pc_out <= pend_addr and clear pend_vld.
  - Any same-cycle redirect request is ignored.
- Alignment check on the selected or captured target: if target[1:0]!=0, go to HALT next cycle.
  - pc_out is not updated with the bad address; fault asserts the same edge.
- Arithmetic: pc_out+4 is modulo 2^PC_WIDTH; 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined:
  - An accepted redirect (or released pending) first advances pc_out to pc_out+4 (delay slot), then to the target on the next non-stalled RUN cycle.
  - Target is held in pend_addr during the slot.
  - Redirects arriving during the delay-slot cycle are ignored.
  - Stall during the slot holds both pc_out and the target.
- Undefined: redirects take effect immediately as above, with no delay slot.

Decomposition:
- Package pc_pkg:
  - state encoding (BOOT/RUN/HALT).
  - redirect-source encoding (SRC_SEQ/SRC_BR/SRC_J/SRC_JR).
  - WORD_BYTES=4.
  - default RESET_VECTOR constant.
- Sub-module pc_redirect_arbiter (combinational):
  - priority select of the target and source encoding.
  - misalignment flag on the selected target.
- pc_sequencer holds the FSM, pc_out register and pending register.

Test Plan:
- Reset release -> cycle 0 BOOT: pc_out=0, fetch_valid=0. Next cycles pc_out = 0, 4, 8 with fetch_valid=1.
- Sequential fetch pc_out=0x100; jump_en=1, jump_target=0x0040_0020, branch_taken=1 same cycle -> next pc_out=0x0040_0020.
- jr_en with jump_en together -> jr_target wins.
- stall=1 for 3 cycles at pc_out=0x200, branch_taken pulse (target 0x300) in stall cycle 1, jump_en (0x400) in stall cycle 2 -> pc_out holds 0x200, then becomes 0x300 on the first unstalled edge; 0x400 is dropped.
- jr_target=0x1002 with jr_en -> next cycle fault=1, state HALT, pc_out unchanged, fetch_valid=0. Stays there until reset; reset returns pc_out=RESET_VECTOR, fault=0.
- pc_out=0xFFFF_FFFC, no redirect -> next pc_out=0x0000_0000.
- BRANCH_DELAY_SLOT_EN: at pc_out=0x40, branch_taken with target 0x80 -> sequence 0x44, 0x80. A jump raised at the 0x44 cycle is ignored.
